// File: rtl/uart_rx_oversampled.sv
// Oversampled 8N1 UART receiver with a one-entry holding register, frame and overrun reporting.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx_oversampled #(
  parameter int TICK_PER_BIT = 16
) (
  input  logic       i_Clock,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic       sample_tick,
  input  logic       i_RX,
  input  logic       i_data_re,
  output logic [7:0] o_data,
  output logic       o_data_valid,
  output logic       o_RX_Active,
  output logic       o_RX_Done,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_parity_err
);

  localparam int CW = $clog2(TICK_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(TICK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(TICK_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t        state;
  logic          rx_meta;
  logic          rx_s;
  logic [CW-1:0] tick_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          par_bad;

`ifdef UART_RX_PARITY_EN
  logic parity_bit;
  logic parity_err_q;

  assign par_bad      = ^{shift, parity_bit};
  assign o_parity_err = parity_err_q;
`else
  assign par_bad      = 1'b0;
  assign o_parity_err = 1'b0;
`endif

  always_ff @(posedge i_Clock) begin
    if (i_reset) begin
      state        <= S_IDLE;
      rx_meta      <= 1'b1;
      rx_s         <= 1'b1;
      tick_cnt     <= '0;
      bit_idx      <= '0;
      shift        <= '0;
      o_data       <= '0;
      o_data_valid <= 1'b0;
      o_RX_Active  <= 1'b0;
      o_RX_Done    <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit   <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      // Pulses default low every cycle, including while disabled.
      o_RX_Done   <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (i_enable) begin
        rx_meta <= i_RX;
        rx_s    <= rx_meta;

        // A good frame loaded in the same cycle overrides this clear below.
        if (i_data_re)
          o_data_valid <= 1'b0;

        if (sample_tick) begin
          case (state)
            S_IDLE: begin
              if (!rx_s) begin
                state    <= S_START;
                tick_cnt <= '0;
              end
            end

            S_START: begin
              if (tick_cnt == HALF_LAST) begin
                tick_cnt <= '0;
                if (rx_s) begin
                  state <= S_IDLE;
                end else begin
                  state       <= S_DATA;
                  bit_idx     <= '0;
                  o_RX_Active <= 1'b1;
                end
              end else begin
                tick_cnt <= tick_cnt + CNT_ONE;
              end
            end

            S_DATA: begin
              if (tick_cnt == BIT_LAST) begin
                tick_cnt       <= '0;
                shift[bit_idx] <= rx_s;
                bit_idx        <= bit_idx + 3'd1;
                if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state <= S_PARITY;
`else
                  state <= S_STOP;
`endif
                end
              end else begin
                tick_cnt <= tick_cnt + CNT_ONE;
              end
            end

`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
              if (tick_cnt == BIT_LAST) begin
                tick_cnt   <= '0;
                parity_bit <= rx_s;
                state      <= S_STOP;
              end else begin
                tick_cnt <= tick_cnt + CNT_ONE;
              end
            end
`endif

            S_STOP: begin
              if (tick_cnt == BIT_LAST) begin
                tick_cnt    <= '0;
                o_RX_Active <= 1'b0;
                state       <= S_IDLE;
                if (rx_s && !par_bad) begin
                  o_data       <= shift;
                  o_data_valid <= 1'b1;
                  o_RX_Done    <= 1'b1;
                  if (o_data_valid && !i_data_re)
                    o_overrun <= 1'b1;
                end
                if (!rx_s)
                  o_frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                if (par_bad)
                  parity_err_q <= 1'b1;
`endif
              end else begin
                tick_cnt <= tick_cnt + CNT_ONE;
              end
            end

            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Randomized frame-level bench for uart_rx_oversampled against a per-frame outcome model.
// Honors UART_RX_PARITY_EN so the same bench covers both builds.
module tb_uart_rx_oversampled;

  localparam int TPB = 16;
  localparam int CPT = 4;
  localparam int CPB = TPB * CPT;
`ifdef UART_RX_PARITY_EN
  localparam int DECIDE_TICKS = 10 * TPB;
`else
  localparam int DECIDE_TICKS = 9 * TPB;
`endif

  logic       i_Clock;
  logic       i_reset;
  logic       i_enable;
  logic       sample_tick;
  logic       i_RX;
  logic       i_data_re;
  logic [7:0] o_data;
  logic       o_data_valid;
  logic       o_RX_Active;
  logic       o_RX_Done;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_parity_err;

  uart_rx_oversampled #(.TICK_PER_BIT(TPB)) dut (
    .i_Clock      (i_Clock),
    .i_reset      (i_reset),
    .i_enable     (i_enable),
    .sample_tick  (sample_tick),
    .i_RX         (i_RX),
    .i_data_re    (i_data_re),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .o_RX_Active  (o_RX_Active),
    .o_RX_Done    (o_RX_Done),
    .o_frame_err  (o_frame_err),
    .o_overrun    (o_overrun),
    .o_parity_err (o_parity_err)
  );

  initial i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;

  // Tick for the coming posedge is set just after the previous one, so it is stable at negedge.
  int phase;
  initial begin
    sample_tick = 1'b0;
    phase = 0;
    forever begin
      @(posedge i_Clock);
      #1;
      phase = (phase + 1) % CPT;
      sample_tick = (phase == 0);
    end
  end

  int n_done, n_ferr, n_ovr, n_perr, n_act;
  logic act_q;
  initial begin
    n_done = 0; n_ferr = 0; n_ovr = 0; n_perr = 0; n_act = 0; act_q = 1'b0;
  end
  always @(negedge i_Clock) begin
    if (o_RX_Done)    n_done++;
    if (o_frame_err)  n_ferr++;
    if (o_overrun)    n_ovr++;
    if (o_parity_err) n_perr++;
    if (o_RX_Active && !act_q) n_act++;
    act_q = o_RX_Active;
  end

  int n_checks, n_bad;
  logic [7:0] exp_data;
  bit exp_valid;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle_clks(input int n);
    i_RX = 1'b1;
    repeat (n) @(negedge i_Clock);
  endtask

  task automatic read_idle();
    i_data_re = 1'b1;
    @(negedge i_Clock);
    i_data_re = 1'b0;
    @(negedge i_Clock);
    exp_valid = 1'b0;
  endtask

  // rt: assert i_data_re exactly on the stop-bit decision cycle, located by counting ticks
  // from the observed start confirmation.
  task automatic send_frame(input logic [7:0] b, input bit stop_b, input bit bad_par,
                            input bit rt, input string tag);
    int d0, f0, o0, p0, a0, nb, tk;
    bit armed, re_pulse, good, e_ovr;
    logic [10:0] bits;
    d0 = n_done; f0 = n_ferr; o0 = n_ovr; p0 = n_perr; a0 = n_act;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef UART_RX_PARITY_EN
    bits[9]  = (^b) ^ bad_par;
    bits[10] = stop_b;
    nb = 11;
`else
    bits[9] = stop_b;
    nb = 10;
`endif
    armed = 1'b0; re_pulse = 1'b0; tk = 0;
    for (int k = 0; k < nb; k++) begin
      i_RX = bits[k];
      for (int c = 0; c < CPB; c++) begin
        @(negedge i_Clock);
        if (re_pulse) begin
          i_data_re = 1'b0;
          re_pulse = 1'b0;
        end
        if (rt) begin
          if (armed && sample_tick) begin
            tk++;
            if (tk == DECIDE_TICKS) begin
              i_data_re = 1'b1;
              re_pulse = 1'b1;
            end
          end
          if (!armed && o_RX_Active) begin
            armed = 1'b1;
            tk = 0;
          end
        end
      end
    end
    i_RX = 1'b1;
`ifndef UART_RX_PARITY_EN
    bad_par = 1'b0;
`endif
    good  = stop_b && !bad_par;
    e_ovr = good && exp_valid && !rt;
    if (good) begin
      exp_data  = b;
      exp_valid = 1'b1;
    end else if (rt) begin
      exp_valid = 1'b0;
    end
    check_eq({tag, "_done"},  n_done - d0, int'(good));
    check_eq({tag, "_ferr"},  n_ferr - f0, int'(!stop_b));
    check_eq({tag, "_ovr"},   n_ovr - o0,  int'(e_ovr));
    check_eq({tag, "_perr"},  n_perr - p0, int'(bad_par));
    check_eq({tag, "_act"},   n_act - a0,  1);
    check_eq({tag, "_data"},  int'(o_data), int'(exp_data));
    check_eq({tag, "_valid"}, int'(o_data_valid), int'(exp_valid));
  endtask

  int d0, f0, o0, p0, a0;
  bit prev_bad;

  initial begin
    n_checks = 0; n_bad = 0;
    exp_data = '0; exp_valid = 1'b0;
    i_reset = 1'b1; i_enable = 1'b1; i_RX = 1'b1; i_data_re = 1'b0;
    repeat (3) @(negedge i_Clock);
    i_reset = 1'b0;
    @(negedge i_Clock);
    check_eq("rst_data",   int'(o_data), 0);
    check_eq("rst_valid",  int'(o_data_valid), 0);
    check_eq("rst_active", int'(o_RX_Active), 0);
    check_eq("rst_pulses", int'({o_RX_Done, o_frame_err, o_overrun, o_parity_err}), 0);
    idle_clks(2 * CPB);

    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, "a5");
    idle_clks(CPB);

    // Short low glitch: shorter than half a bit, must be rejected.
    d0 = n_done; f0 = n_ferr; o0 = n_ovr; a0 = n_act;
    i_RX = 1'b0;
    repeat (4 * CPT) @(negedge i_Clock);
    idle_clks(2 * CPB);
    check_eq("glitch_act",    n_act - a0, 0);
    check_eq("glitch_pulses", (n_done - d0) + (n_ferr - f0) + (n_ovr - o0), 0);
    check_eq("glitch_valid",  int'(o_data_valid), int'(exp_valid));

    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, "ferr3c");
    idle_clks(2 * CPB);

    read_idle();
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, "b2b11");
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, "b2b22");
    idle_clks(CPB);

    send_frame(8'h44, 1'b1, 1'b0, 1'b1, "rdsame");
    idle_clks(CPB);

    // Reset during bit 4 of 0xFF; the rest of that frame is all high.
    d0 = n_done; f0 = n_ferr; o0 = n_ovr; p0 = n_perr;
    i_RX = 1'b0;
    repeat (CPB) @(negedge i_Clock);
    i_RX = 1'b1;
    repeat (4 * CPB + CPB / 2) @(negedge i_Clock);
    i_reset = 1'b1;
    repeat (2) @(negedge i_Clock);
    i_reset = 1'b0;
    exp_data = '0; exp_valid = 1'b0;
    check_eq("midrst_active", int'(o_RX_Active), 0);
    check_eq("midrst_data",   int'(o_data), 0);
    idle_clks(7 * CPB);
    check_eq("midrst_pulses", (n_done - d0) + (n_ferr - f0) + (n_ovr - o0) + (n_perr - p0), 0);
    check_eq("midrst_valid",  int'(o_data_valid), 0);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, "post5a");
    idle_clks(CPB);

    // Disabled: read strobe and line activity are ignored.
    i_enable = 1'b0;
    d0 = n_done; f0 = n_ferr; a0 = n_act;
    i_data_re = 1'b1;
    i_RX = 1'b0;
    repeat (2 * CPB) @(negedge i_Clock);
    check_eq("dis_valid", int'(o_data_valid), int'(exp_valid));
    i_data_re = 1'b0;
    i_RX = 1'b1;
    repeat (CPB) @(negedge i_Clock);
    i_enable = 1'b1;
    idle_clks(2 * CPB);
    check_eq("dis_valid2", int'(o_data_valid), int'(exp_valid));
    check_eq("dis_quiet",  (n_done - d0) + (n_ferr - f0) + (n_act - a0), 0);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, "par07bad");
    idle_clks(CPB);
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, "par07ok");
    idle_clks(CPB);
`endif

    prev_bad = 1'b0;
    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      bit stop_b, bad_par, rt;
      int gap;
      b       = 8'($urandom);
      stop_b  = ($urandom % 6) != 0;
      bad_par = ($urandom % 5) == 0;
      rt      = ($urandom % 5) == 0;
      gap     = prev_bad ? 2 : int'($urandom % 3);
      idle_clks(gap * CPB);
      if (($urandom % 3) == 0) read_idle();
      send_frame(b, stop_b, bad_par, rt, $sformatf("rnd%0d", n));
      prev_bad = !stop_b;
    end
    idle_clks(2 * CPB);
    check_eq("end_valid", int'(o_data_valid), int'(exp_valid));

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
